// File: rtl/alp_cmd_driver_if.sv
// Bundle of the command, ALP-side and response signals of the ALP command driver.
// The driver uses the master view; the host/ALP side (or a bench) uses the slave view.
interface alp_cmd_driver_if;
    // command port
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic       cmd_clr;
    // ALP drive / observe
    logic [3:0] alp_data;
    logic [2:0] alp_op;
    logic       alp_load;
    logic       alp_comp;
    logic       alp_clr;
    logic [3:0] alp_out_0;
    logic [3:0] alp_out_1;
    logic       alp_err;
    // response port
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_r0;
    logic [3:0] rsp_r1;
    logic       rsp_err;
    // status
    logic       busy;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_clr,
        input  alp_out_0, alp_out_1, alp_err,
        input  rsp_ready,
        output cmd_ready,
        output alp_data, alp_op, alp_load, alp_comp, alp_clr,
        output rsp_valid, rsp_r0, rsp_r1, rsp_err,
        output busy
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_clr,
        output alp_out_0, alp_out_1, alp_err,
        output rsp_ready,
        input  cmd_ready,
        input  alp_data, alp_op, alp_load, alp_comp, alp_clr,
        input  rsp_valid, rsp_r0, rsp_r1, rsp_err,
        input  busy
    );
endinterface

// File: rtl/alp_cmd_driver.sv
// ALP command driver: takes one (A, B, op) command, sequences clr/load/comp
// strobes towards the ALP, waits a fixed compute window, samples the ALP
// results and hands them back on a valid/ready response port.
// All outputs are registered: the next-state logic also computes the next
// value of every output, and the state register process stores both.
module alp_cmd_driver #(
    parameter int GAP_CYCLES  = 1,
    parameter int COMP_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    alp_cmd_driver_if.master  bus
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CLR    = 4'd1,
        ST_LOAD_A = 4'd2,
        ST_GAP_A  = 4'd3,
        ST_LOAD_B = 4'd4,
        ST_GAP_B  = 4'd5,
        ST_COMP   = 4'd6,
        ST_WAIT   = 4'd7,
        ST_RESP   = 4'd8
    } state_t;

    // Counter reload values are N-1 so the last counted cycle is the one at zero.
    localparam bit              HAS_GAP   = (GAP_CYCLES > 0);
    localparam logic [CNT_W-1:0] GAP_LOAD  = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] COMP_LOAD = CNT_W'(COMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // state and counter
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // latched command
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [2:0] op_r;

    // registered outputs and their next values
    logic       cmd_ready_r, cmd_ready_nxt_s;
    logic       busy_r,      busy_nxt_s;
    logic [3:0] alp_data_r,  alp_data_nxt_s;
    logic [2:0] alp_op_r,    alp_op_nxt_s;
    logic       alp_load_r,  alp_load_nxt_s;
    logic       alp_comp_r,  alp_comp_nxt_s;
    logic       alp_clr_r,   alp_clr_nxt_s;
    logic       rsp_valid_r, rsp_valid_nxt_s;
    logic [3:0] rsp_r0_r,    rsp_r0_nxt_s;
    logic [3:0] rsp_r1_r,    rsp_r1_nxt_s;
    logic       rsp_err_r,   rsp_err_nxt_s;

    logic       accept_s;
    logic [3:0] cur_a_s;

    assign accept_s = bus.cmd_valid & cmd_ready_r;

    // On the accept edge the latch is not yet loaded, so A comes straight from the port.
    assign cur_a_s = (state_r == ST_IDLE) ? bus.cmd_a : a_r;

    // Next-state, counter and next-output computation.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (bus.cmd_clr) begin
                        state_nxt_s = ST_CLR;
                    end else begin
                        state_nxt_s = ST_LOAD_A;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLR: begin
                state_nxt_s = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                if (HAS_GAP) begin
                    state_nxt_s = ST_GAP_A;
                    cnt_nxt_s   = GAP_LOAD;
                end else begin
                    state_nxt_s = ST_LOAD_B;
                end
            end
            ST_GAP_A: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_LOAD_B;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_LOAD_B: begin
                if (HAS_GAP) begin
                    state_nxt_s = ST_GAP_B;
                    cnt_nxt_s   = GAP_LOAD;
                end else begin
                    state_nxt_s = ST_COMP;
                end
            end
            ST_GAP_B: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_COMP;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_COMP: begin
                state_nxt_s = ST_WAIT;
                cnt_nxt_s   = COMP_LOAD;
            end
            ST_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase

        // Strobes and status follow the state being entered, one cycle each.
        cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        alp_load_nxt_s  = (state_nxt_s == ST_LOAD_A) || (state_nxt_s == ST_LOAD_B);
        alp_comp_nxt_s  = (state_nxt_s == ST_COMP);
        alp_clr_nxt_s   = (state_nxt_s == ST_CLR);
        rsp_valid_nxt_s = (state_nxt_s == ST_RESP);

        // Data bus holds its last operand through the gap and beyond.
        if (state_nxt_s == ST_LOAD_A) begin
            alp_data_nxt_s = cur_a_s;
        end else if (state_nxt_s == ST_LOAD_B) begin
            alp_data_nxt_s = b_r;
        end else begin
            alp_data_nxt_s = alp_data_r;
        end

        // Opcode is presented with comp and held through the wait window.
        if (state_nxt_s == ST_COMP) begin
            alp_op_nxt_s = op_r;
        end else begin
            alp_op_nxt_s = alp_op_r;
        end

        // ALP results are captured only on the edge that ends the wait window.
        if ((state_r == ST_WAIT) && (state_nxt_s == ST_RESP)) begin
            rsp_r0_nxt_s  = bus.alp_out_0;
            rsp_r1_nxt_s  = bus.alp_out_1;
            rsp_err_nxt_s = bus.alp_err;
        end else begin
            rsp_r0_nxt_s  = rsp_r0_r;
            rsp_r1_nxt_s  = rsp_r1_r;
            rsp_err_nxt_s = rsp_err_r;
        end
    end

    // State, counter and registered outputs; reset drops any in-flight command.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            alp_data_r  <= 4'h0;
            alp_op_r    <= 3'b000;
            alp_load_r  <= 1'b0;
            alp_comp_r  <= 1'b0;
            alp_clr_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_r0_r    <= 4'h0;
            rsp_r1_r    <= 4'h0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            cmd_ready_r <= cmd_ready_nxt_s;
            busy_r      <= busy_nxt_s;
            alp_data_r  <= alp_data_nxt_s;
            alp_op_r    <= alp_op_nxt_s;
            alp_load_r  <= alp_load_nxt_s;
            alp_comp_r  <= alp_comp_nxt_s;
            alp_clr_r   <= alp_clr_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_r0_r    <= rsp_r0_nxt_s;
            rsp_r1_r    <= rsp_r1_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
        end
    end

    // Command latch: operands are frozen at the accept edge; later port changes are ignored.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_r  <= 4'h0;
            b_r  <= 4'h0;
            op_r <= 3'b000;
        end else if (accept_s) begin
            a_r  <= bus.cmd_a;
            b_r  <= bus.cmd_b;
            op_r <= bus.cmd_op;
        end else begin
            a_r  <= a_r;
            b_r  <= b_r;
            op_r <= op_r;
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.busy      = busy_r;
    assign bus.alp_data  = alp_data_r;
    assign bus.alp_op    = alp_op_r;
    assign bus.alp_load  = alp_load_r;
    assign bus.alp_comp  = alp_comp_r;
    assign bus.alp_clr   = alp_clr_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_r0    = rsp_r0_r;
    assign bus.rsp_r1    = rsp_r1_r;
    assign bus.rsp_err   = rsp_err_r;

endmodule
